xc_aesmix: RTL and testbench

XC_AESMIX -- requirements
Module: xc_aesmix

---
 rtl/xc_aes_pkg.sv | 24 ++
 rtl/xc_aesmix_byte.sv | 18 +
 rtl/xc_aesmix.sv | 82 ++++++++
 tb/tb_xc_aesmix.sv | 175 +++++++++++++++++
 4 files changed

// File: rtl/xc_aes_pkg.sv
// xc_aes_pkg: shared constants, state encoding and GF(2^8) helpers for xc_aesmix.
package xc_aes_pkg;

    localparam logic [7:0] POLY = 8'h1b;

    typedef enum logic [1:0] {S0 = 2'd0, S1 = 2'd1, S2 = 2'd2, S3 = 2'd3} state_t;

    // Entry k is the coefficient applied to a(i+k); all fit in 4 bits.
    localparam logic [3:0][3:0] ENC_COEF = {4'h1, 4'h1, 4'h3, 4'h2};
    localparam logic [3:0][3:0] DEC_COEF = {4'h9, 4'hd, 4'hb, 4'he};

    function automatic logic [7:0] xtime(input logic [7:0] b);
        return {b[6:0], 1'b0} ^ (b[7] ? POLY : 8'h00);
    endfunction

    function automatic logic [7:0] gmul(input logic [7:0] x, input logic [3:0] c);
        logic [7:0] x2, x4, x8;
        x2 = xtime(x);
        x4 = xtime(x2);
        x8 = xtime(x4);
        return ({8{c[0]}} & x) ^ ({8{c[1]}} & x2) ^ ({8{c[2]}} & x4) ^ ({8{c[3]}} & x8);
    endfunction

endpackage

// File: rtl/xc_aesmix_byte.sv
// xc_aesmix_byte: one output byte of (Inv)MixColumns from a rotated column x0..x3.
module xc_aesmix_byte
    import xc_aes_pkg::*;
(
    input  logic [7:0] x0,
    input  logic [7:0] x1,
    input  logic [7:0] x2,
    input  logic [7:0] x3,
    input  logic       enc,
    output logic [7:0] y
);

    logic [3:0][3:0] c;

    assign c = enc ? ENC_COEF : DEC_COEF;
    assign y = gmul(x0, c[0]) ^ gmul(x1, c[1]) ^ gmul(x2, c[2]) ^ gmul(x3, c[3]);

endmodule

// File: rtl/xc_aesmix.sv
// xc_aesmix: AES (Inv)MixColumns on one column, either single-cycle (FAST)
// or one byte per cycle through a single shared byte unit.
module xc_aesmix
    import xc_aes_pkg::*;
#(
    parameter logic FAST = 1'b0
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        flush,
    input  logic [31:0] flush_data,
    input  logic        valid,
    input  logic [31:0] rs1,
    input  logic [31:0] rs2,
    input  logic        enc,
    output logic        ready,
    output logic [31:0] result
);

    logic [3:0][7:0] a;
    logic            unused_bits;

    assign a           = {rs2[31:24], rs2[23:16], rs1[15:8], rs1[7:0]};
    assign unused_bits = &{1'b0, rs1[31:16], rs2[15:0], flush_data[31:24]};

    if (FAST) begin : g_fast
        logic [3:0][7:0] b;
        logic            unused_fast;

        assign unused_fast = &{1'b0, clock, reset, flush, flush_data[23:0]};

        for (genvar i = 0; i < 4; i++) begin : g_unit
            xc_aesmix_byte u_byte (
                .x0 (valid ? a[i]         : 8'h00),
                .x1 (valid ? a[(i+1) % 4] : 8'h00),
                .x2 (valid ? a[(i+2) % 4] : 8'h00),
                .x3 (valid ? a[(i+3) % 4] : 8'h00),
                .enc(enc),
                .y  (b[i])
            );
        end

        assign ready  = valid;
        assign result = b;
    end else begin : g_slow
        state_t          fsm;
        logic [2:0][7:0] b_q;
        logic [1:0]      s;
        logic [7:0]      u;

        assign s = fsm;

        // The column is rotated by the state so the same unit yields b0..b3 in turn.
        xc_aesmix_byte u_byte (
            .x0 (valid ? a[s]         : 8'h00),
            .x1 (valid ? a[s + 2'd1]  : 8'h00),
            .x2 (valid ? a[s + 2'd2]  : 8'h00),
            .x3 (valid ? a[s + 2'd3]  : 8'h00),
            .enc(enc),
            .y  (u)
        );

        always_ff @(posedge clock or posedge reset) begin
            if (reset) begin
                fsm <= S0;
                b_q <= '0;
            end else if (flush) begin
                fsm <= S0;
                b_q <= flush_data[23:0];
            end else if (!valid) begin
                fsm <= S0;
            end else begin
                fsm <= state_t'(s + 2'd1);
                if (fsm != S3) b_q[s] <= u;
            end
        end

        assign ready  = (fsm == S3) && valid && !flush;
        assign result = {u, b_q};
    end

endmodule

// File: tb/tb_xc_aesmix.sv
// tb_xc_aesmix: checks slow and fast xc_aesmix variants against a GF(2^8) matrix model.
module tb_xc_aesmix;

    logic        clock = 1'b0;
    logic        reset = 1'b1;
    logic        flush = 1'b0;
    logic [31:0] flush_data = '0;
    logic        valid = 1'b0;
    logic [31:0] rs1 = '0;
    logic [31:0] rs2 = '0;
    logic        enc = 1'b0;
    logic        ready, ready_f;
    logic [31:0] result, result_f;
    int          total = 0;
    int          bad = 0;

    always #5 clock = ~clock;

    xc_aesmix #(.FAST(1'b0)) dut (
        .clock(clock), .reset(reset), .flush(flush), .flush_data(flush_data),
        .valid(valid), .rs1(rs1), .rs2(rs2), .enc(enc), .ready(ready), .result(result)
    );

    xc_aesmix #(.FAST(1'b1)) dut_f (
        .clock(clock), .reset(reset), .flush(flush), .flush_data(flush_data),
        .valid(valid), .rs1(rs1), .rs2(rs2), .enc(enc), .ready(ready_f), .result(result_f)
    );

    function automatic logic [7:0] gm(input logic [7:0] x, input logic [7:0] y);
        logic [15:0] p;
        p = '0;
        for (int i = 0; i < 8; i++) if (y[i]) p = p ^ (16'(x) << i);
        for (int i = 15; i >= 8; i--) if (p[i]) p = p ^ (16'h011b << (i - 8));
        return p[7:0];
    endfunction

    function automatic logic [31:0] model(input logic [31:0] r1, input logic [31:0] r2, input logic e);
        logic [7:0] a [4];
        logic [7:0] k [4];
        logic [31:0] r;
        a[0] = r1[7:0]; a[1] = r1[15:8]; a[2] = r2[23:16]; a[3] = r2[31:24];
        if (e) begin k[0] = 8'h02; k[1] = 8'h03; k[2] = 8'h01; k[3] = 8'h01; end
        else begin k[0] = 8'h0e; k[1] = 8'h0b; k[2] = 8'h0d; k[3] = 8'h09; end
        r = '0;
        for (int i = 0; i < 4; i++)
            for (int j = 0; j < 4; j++) r[8*i +: 8] = r[8*i +: 8] ^ gm(k[j], a[(i+j) % 4]);
        return r;
    endfunction

    task automatic cyc;
        @(posedge clock);
        #1;
    endtask

    // Holds one operation for four cycles, checking ready timing and both results.
    task automatic run_op(input logic [31:0] r1, input logic [31:0] r2, input logic e,
                          input logic [31:0] exp, input string name);
        rs1 = r1; rs2 = r2; enc = e; valid = 1'b1;
        for (int c = 1; c <= 4; c++) begin
            #1;
            total++;
            if (ready !== (c == 4)) begin
                bad++;
                $display("FAIL %s ready cycle %0d: got %b want %b", name, c, ready, c == 4);
            end
            if (c == 4) begin
                total++;
                if (result !== exp) begin
                    bad++;
                    $display("FAIL %s result: got %h want %h", name, result, exp);
                end
            end
            total++;
            if (ready_f !== 1'b1 || result_f !== exp) begin
                bad++;
                $display("FAIL %s fast cycle %0d: got %b/%h want 1/%h", name, c, ready_f, result_f, exp);
            end
            cyc();
        end
    endtask

    task automatic test_reset;
        repeat (2) cyc();
        total++;
        if (ready !== 1'b0 || dut.g_slow.b_q !== 24'h0) begin
            bad++;
            $display("FAIL reset: got ready=%b b=%h want 0/000000", ready, dut.g_slow.b_q);
        end
        reset = 1'b0;
    endtask

    task automatic test_vectors;
        run_op(32'h000013db, 32'h45530000, 1'b1, 32'hbca14d8e, "enc_vec");
        run_op(32'h00004d8e, 32'hbca10000, 1'b0, 32'h455313db, "dec_vec");
        run_op(32'hffffc6c6, 32'hc6c6ffff, 1'b1, 32'hc6c6c6c6, "c6_ignored");
        run_op(32'h0000c6c6, 32'hc6c60000, 1'b1, 32'hc6c6c6c6, "c6_clean");
    endtask

    task automatic test_abort;
        rs1 = 32'h000013db; rs2 = 32'h45530000; enc = 1'b1; valid = 1'b1;
        cyc(); cyc();
        valid = 1'b0;
        #1;
        total++;
        if (ready !== 1'b0 || ready_f !== 1'b0) begin
            bad++;
            $display("FAIL abort: got ready=%b fast=%b want 0/0", ready, ready_f);
        end
        cyc();
        run_op(32'h00000101, 32'h01010000, 1'b1, 32'h01010101, "after_abort");
    endtask

    task automatic test_flush;
        rs1 = 32'h000013db; rs2 = 32'h45530000; enc = 1'b1; valid = 1'b1;
        cyc();
        flush = 1'b1; flush_data = 32'h00a5a5a5;
        #1;
        total++;
        if (ready !== 1'b0) begin
            bad++;
            $display("FAIL flush ready: got %b want 0", ready);
        end
        cyc();
        flush = 1'b0;
        total++;
        if (dut.g_slow.b_q !== 24'ha5a5a5) begin
            bad++;
            $display("FAIL flush data: got %h want a5a5a5", dut.g_slow.b_q);
        end
        run_op(32'h00004d8e, 32'hbca10000, 1'b0, 32'h455313db, "after_flush");
    endtask

    task automatic test_reset_mid;
        rs1 = 32'h000013db; rs2 = 32'h45530000; enc = 1'b1; valid = 1'b1;
        cyc(); cyc();
        #2 reset = 1'b1;
        #1;
        total++;
        if (ready !== 1'b0 || dut.g_slow.b_q !== 24'h0) begin
            bad++;
            $display("FAIL reset_mid: got ready=%b b=%h want 0/000000", ready, dut.g_slow.b_q);
        end
        cyc();
        reset = 1'b0;
        run_op(32'h000013db, 32'h45530000, 1'b1, 32'hbca14d8e, "after_reset");
    endtask

    task automatic test_back_to_back;
        run_op(32'h000013db, 32'h45530000, 1'b1, 32'hbca14d8e, "b2b_first");
        run_op(32'h00004d8e, 32'hbca10000, 1'b0, 32'h455313db, "b2b_second");
    endtask

    task automatic test_random;
        logic [31:0] r1, r2;
        logic        e;
        for (int n = 0; n < 24; n++) begin
            r1 = $urandom; r2 = $urandom; e = 1'($urandom_range(0, 1));
            run_op(r1, r2, e, model(r1, r2, e), "random");
        end
    endtask

    initial begin
        test_reset();
        test_vectors();
        test_abort();
        test_flush();
        test_reset_mid();
        test_back_to_back();
        test_random();
        valid = 1'b0;
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
